commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Passive observer on the single-cycle CPU's retire-side signals (pc, insc, wea_reg, write_reg, r3_din, MemWrite).
- Arms, triggers on a programmed PC, then captures a fixed number of per-cycle commit records into a circular FIFO.
- A downstream consumer (bench checker or debug UART) drains the FIFO over a valid/ready read port.
- Provides the reading end of the CPU's commit stream, which the CPU top writes once per clock.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- AW, 4, pointer width, equal to log2(DEPTH).
- POST_CNT, 12, records captured after the trigger, including the trigger record; range 1..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  one-cycle pulse; effective only in IDLE.
- clr  in  1  synchronous flush: empties FIFO, zeroes counters, returns FSM to IDLE; overrides all other inputs.
- trig_pc  in  8  PC value that fires the trigger.
- pc  in  8  CPU program counter.
- insc  in  32  instruction at pc.
- wea_reg  in  1  register-file write enable.
- write_reg  in  5  destination register.
- r3_din  in  32  register write-back data.
- MemWrite  in  1  data-memory write enable.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts the head entry.
- rd_data  out  79  head record, packed as {pc, insc, wea_reg, write_reg, r3_din, MemWrite}, MSB first.
- count  out  AW+1  current occupancy, 0..DEPTH.
- drop_cnt  out  16  records lost because the FIFO was full; saturates at 0xFFFF.
- state  out  2  FSM state, for debug.

Behaviour:
- Reset (rst_n low, asynchronous):
  - Pointers, count, and drop_cnt are cleared to 0.
  - state is IDLE, so rd_valid is 0.
  - rd_data is don't-care while rd_valid is 0.
- FSM states: IDLE=0, ARMED=1, RUN=2, STOP=3.
  - IDLE → ARMED on arm.
  - ARMED → RUN on the cycle pc==trig_pc. That cycle's record is captured and the post counter is loaded with POST_CNT-1.
  - RUN captures one record every cycle and decrements the post counter. It moves to STOP on the cycle the post counter reaches 0.
  - With POST_CNT=1, the FSM goes ARMED → STOP directly after capturing the trigger record.
  - STOP is held until clr. arm is ignored in every state except IDLE.
- Capture happens on every cycle where the FSM is in RUN, or in ARMED with the trigger matching.
  - If count==DEPTH with no pop in the same cycle, the record is dropped and drop_cnt increments.
  - The post counter still decrements on a dropped record, so trace length is fixed in cycles.
- Read port:
  - rd_valid = (count != 0).
  - rd_data is read combinationally from mem[rd_ptr] (first-word fall-through).
  - A pop occurs when rd_valid && rd_ready. rd_data must stay stable while rd_valid && !rd_ready.
- Simultaneous push and pop:
  - Both take effect in the same cycle and count is unchanged.
  - When full, the push is accepted, because the pop frees a slot in that same cycle. No drop is counted.
  - A pop while empty is ignored.
- Pointers are AW bits wide and wrap modulo DEPTH. count is tracked separately to distinguish full from empty.
- clr during RUN: the current-cycle capture is discarded and the block goes to IDLE on the next edge.
- Asynchronous reset mid-capture: everything is cleared immediately. Data already captured is lost.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- When defined, a capture-qualifying cycle is pushed only if wea_reg || MemWrite. Skipped cycles still decrement the post counter and never count as drops. The trigger cycle itself is also subject to this filter.
- When undefined, every qualifying cycle is pushed.

Decomposition:
- Shared package cpu_dbg_pkg contains:
  - FSM state encodings (IDLE, ARMED, RUN, STOP).
  - TRACE_REC_W = 79.
  - Field offset localparams for unpacking rd_data.
- One natural sub-module: trace_fifo, a generic FIFO parameterised by width and depth, with push, pop, count, full, empty, and FWFT read.
- The top level holds the FSM, post counter, filter, drop counter, and record packing.

Test Plan:
- Reset, then arm; pc steps 0,4,8,…; trig_pc=8 → state becomes RUN at the pc=8 cycle. STOP is reached 12 cycles later, count=12, head rd_data pc field = 8, last record pc field = 52.
- Hold rd_ready=0 with POST_CNT=20, DEPTH=16 → count saturates at 16, drop_cnt=4, state=STOP. Draining then yields pc values 8..68 in order.
- Keep rd_ready=1 and full during RUN → simultaneous push and pop; count stays 16 and drop_cnt stays 0.
- Assert clr mid-RUN → next cycle state=IDLE, count=0, rd_valid=0, drop_cnt=0. A later arm re-triggers correctly.
- Pulse rst_n low between clock edges while count=5 → outputs clear immediately, without waiting for clk.
- With TRACE_FILTER_EN defined and wea_reg=1 on alternate cycles, POST_CNT=12 → exactly 6 records pushed, all with the wea_reg bit set.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared trace FSM encodings and commit record field layout
package cpu_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_STOP  = 2'd3
    } trace_state_t;

    localparam int TRACE_REC_W = 79;

    // Record layout, MSB first: {pc, insc, wea_reg, write_reg, r3_din, MemWrite}
    localparam int REC_MEMWRITE_BIT  = 0;
    localparam int REC_R3_DIN_LSB    = 1;
    localparam int REC_WRITE_REG_LSB = 33;
    localparam int REC_WEA_REG_BIT   = 38;
    localparam int REC_INSC_LSB      = 39;
    localparam int REC_PC_LSB        = 71;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - generic first-word-fall-through FIFO with occupancy count and flush
module trace_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign count = cnt;
    assign rdata = mem[rd_ptr];

    // A pop on a full FIFO frees the slot the same-cycle push needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage needs no reset; only entries below count are ever observed.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at AW bits; cnt separates full from empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// rtl/commit_trace_buffer.sv - PC-triggered commit trace capture; optional TRACE_FILTER_EN keeps only writing cycles
module commit_trace_buffer
    import cpu_dbg_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int AW       = 4,
    parameter int POST_CNT = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   arm,
    input  logic                   clr,
    input  logic [7:0]             trig_pc,
    input  logic [7:0]             pc,
    input  logic [31:0]            insc,
    input  logic                   wea_reg,
    input  logic [4:0]             write_reg,
    input  logic [31:0]            r3_din,
    input  logic                   MemWrite,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [TRACE_REC_W-1:0] rd_data,
    output logic [AW:0]            count,
    output logic [15:0]            drop_cnt,
    output logic [1:0]             state
);

    localparam logic [7:0] POST_LAST = 8'(POST_CNT - 1);

    trace_state_t           st_q;
    trace_state_t           st_nxt;
    logic [7:0]             post_q;
    logic [7:0]             post_nxt;
    logic [TRACE_REC_W-1:0] rec;
    logic                   trig_hit;
    logic                   capture;
    logic                   keep;
    logic                   push_req;
    logic                   full;
    logic                   empty;
    logic                   drop;

    assign rec[REC_PC_LSB +: 8]        = pc;
    assign rec[REC_INSC_LSB +: 32]     = insc;
    assign rec[REC_WEA_REG_BIT]        = wea_reg;
    assign rec[REC_WRITE_REG_LSB +: 5] = write_reg;
    assign rec[REC_R3_DIN_LSB +: 32]   = r3_din;
    assign rec[REC_MEMWRITE_BIT]       = MemWrite;

    assign trig_hit = (pc == trig_pc);
    assign capture  = (st_q == ST_RUN) || ((st_q == ST_ARMED) && trig_hit);

`ifdef TRACE_FILTER_EN
    assign keep = wea_reg | MemWrite;
`else
    assign keep = 1'b1;
`endif

    // Filtered-out cycles still consume trace length but are never drops.
    assign push_req = capture && keep && !clr;
    assign drop     = push_req && full && !rd_ready;
    assign rd_valid = !empty;
    assign state    = st_q;

    trace_fifo #(
        .W     (TRACE_REC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push_req),
        .pop   (rd_ready),
        .wdata (rec),
        .rdata (rd_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // FSM state and post-trigger countdown registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= ST_IDLE;
            post_q <= '0;
        end else begin
            st_q   <= st_nxt;
            post_q <= post_nxt;
        end
    end

    // Next state: trigger loads remaining record count, RUN counts it down.
    always_comb begin
        st_nxt   = st_q;
        post_nxt = post_q;
        if (clr) begin
            st_nxt   = ST_IDLE;
            post_nxt = '0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (arm) begin
                        st_nxt = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (trig_hit) begin
                        post_nxt = POST_LAST;
                        st_nxt   = (POST_LAST == 8'd0) ? ST_STOP : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (post_q <= 8'd1) begin
                        post_nxt = '0;
                        st_nxt   = ST_STOP;
                    end else begin
                        post_nxt = post_q - 8'd1;
                    end
                end
                default: begin
                    st_nxt = ST_STOP;
                end
            endcase
        end
    end

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (clr) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_commit_trace_buffer.sv
// tb/tb_commit_trace_buffer.sv - self-checking bench for commit_trace_buffer
module tb_commit_trace_buffer;
    import cpu_dbg_pkg::*;

    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int POST_CNT = 20;
`ifdef TRACE_FILTER_EN
    localparam bit FILTER = 1'b1;
`else
    localparam bit FILTER = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm;
    logic        clr;
    logic [7:0]  trig_pc;
    logic [7:0]  pc;
    logic [31:0] insc;
    logic        wea_reg;
    logic [4:0]  write_reg;
    logic [31:0] r3_din;
    logic        MemWrite;
    logic        rd_valid;
    logic        rd_ready;
    logic [78:0] rd_data;
    logic [AW:0] count;
    logic [15:0] drop_cnt;
    logic [1:0]  state;

    int checks = 0;
    int passes = 0;

    int          m_state;
    int          m_taken;
    int          m_drops;
    logic [78:0] mq[$];

    commit_trace_buffer #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .POST_CNT (POST_CNT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arm       (arm),
        .clr       (clr),
        .trig_pc   (trig_pc),
        .pc        (pc),
        .insc      (insc),
        .wea_reg   (wea_reg),
        .write_reg (write_reg),
        .r3_din    (r3_din),
        .MemWrite  (MemWrite),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .count     (count),
        .drop_cnt  (drop_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;

    function automatic logic [78:0] cur_rec();
        return {pc, insc, wea_reg, write_reg, r3_din, MemWrite};
    endfunction

    task automatic check(input string tag, input logic [78:0] obs, input logic [78:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_taken = 0;
        m_drops = 0;
    endtask

    // Reference: a queue of records plus "records of trace taken so far".
    task automatic model_edge();
        bit pop_m;
        bit cap;
        bit keep;
        if (clr) begin
            model_reset();
        end else begin
            pop_m = (mq.size() != 0) && rd_ready;
            cap   = (m_state == 2) || (m_state == 1 && pc == trig_pc);
            keep  = !FILTER || wea_reg || MemWrite;
            if (pop_m) void'(mq.pop_front());
            if (cap && keep) begin
                if (mq.size() < DEPTH) mq.push_back(cur_rec());
                else if (m_drops < 65535) m_drops++;
            end
            if (m_state == 0) begin
                if (arm) m_state = 1;
            end else if (m_state == 1) begin
                if (pc == trig_pc) begin
                    m_taken = 1;
                    m_state = (m_taken == POST_CNT) ? 3 : 2;
                end
            end else if (m_state == 2) begin
                m_taken++;
                if (m_taken == POST_CNT) m_state = 3;
            end
        end
    endtask

    task automatic check_all();
        check("state", state, m_state);
        check("count", count, mq.size());
        check("rd_valid", rd_valid, mq.size() != 0);
        check("drop_cnt", drop_cnt, m_drops);
        if (mq.size() != 0) check("rd_data", rd_data, mq[0]);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive_cpu(input logic [7:0] p);
        pc        = p;
        insc      = $urandom;
        wea_reg   = 1'($urandom_range(0, 1));
        write_reg = 5'($urandom_range(0, 31));
        r3_din    = $urandom;
        MemWrite  = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_clr();
        arm      = 1'b0;
        clr      = 1'b1;
        rd_ready = 1'b0;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        arm      = 1'b0;
        clr      = 1'b0;
        trig_pc  = 8'd0;
        rd_ready = 1'b0;
        drive_cpu(8'd0);
        model_reset();
        #12;
        check("rst_state", state, 0);
        check("rst_count", count, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_drop", drop_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Trigger at pc=8, consumer stalled: fills to 16, drops 4, then drain.
        trig_pc = 8'd8;
        for (int i = 0; i < 30; i++) begin
            drive_cpu(8'(4 * i));
            wea_reg = 1'b1;
            arm     = (i == 0);
            step();
            if (i == 2) check("trig_run", state, 2);
        end
        arm = 1'b0;
        check("a_stop", state, 3);
        check("a_full", count, 16);
        check("a_drops", drop_cnt, 4);
        rd_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("drain_pc", rd_data[REC_PC_LSB +: 8], 8 + 4 * k);
            step();
        end
        check("a_empty", rd_valid, 0);

        // Full FIFO during RUN with consumer ready: push and pop together.
        idle_clr();
        for (int i = 0; i < 30; i++) begin
            drive_cpu(8'(4 * i));
            wea_reg  = 1'b1;
            arm      = (i == 0);
            rd_ready = (m_state == 2) && (mq.size() == DEPTH);
            step();
        end
        arm      = 1'b0;
        rd_ready = 1'b0;
        check("b_count", count, 16);
        check("b_drops", drop_cnt, 0);
        check("b_head_pc", rd_data[REC_PC_LSB +: 8], 24);

        // clr in the middle of RUN, then a fresh arm and trigger.
        idle_clr();
        for (int i = 0; i < 40; i++) begin
            drive_cpu(8'(4 * i));
            arm      = (i == 0) || (i == 7);
            clr      = (i == 5);
            trig_pc  = (i < 6) ? 8'd8 : 8'd40;
            rd_ready = 1'($urandom_range(0, 1));
            step();
            if (i == 5) begin
                check("c_clr_state", state, 0);
                check("c_clr_count", count, 0);
                check("c_clr_valid", rd_valid, 0);
                check("c_clr_drop", drop_cnt, 0);
            end
            if (i == 10) check("c_retrig", state, 2);
        end
        clr = 1'b0;
        arm = 1'b0;

        // Alternate-cycle write enables; filtered build keeps only wea_reg cycles.
        idle_clr();
        trig_pc = 8'd8;
        for (int i = 0; i < 30; i++) begin
            drive_cpu(8'(4 * i));
            wea_reg  = i[0];
            MemWrite = 1'b0;
            arm      = (i == 0);
            step();
        end
        arm = 1'b0;

        // Randomised traffic on a small pc range.
        idle_clr();
        for (int i = 0; i < 600; i++) begin
            drive_cpu(8'($urandom_range(0, 7)));
            if (i % 50 == 0) trig_pc = 8'($urandom_range(0, 7));
            arm      = ($urandom_range(0, 9) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            rd_ready = (i % 200 < 60) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            step();
        end
        arm = 1'b0;
        clr = 1'b0;

        // Asynchronous reset between edges with five records held.
        idle_clr();
        trig_pc = 8'd8;
        for (int i = 0; i < 20 && mq.size() != 5; i++) begin
            drive_cpu(8'(4 * i));
            wea_reg = 1'b1;
            arm     = (i == 0);
            step();
        end
        arm = 1'b0;
        check("e_count5", count, 5);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_async_state", state, 0);
        check("e_async_count", count, 0);
        check("e_async_valid", rd_valid, 0);
        check("e_async_drop", drop_cnt, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_cpu(8'd8);
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
